// File: rtl/trap_controller_pkg.sv
// rtl/trap_controller_pkg.sv - exception codes, privilege states and region vectors for the trap controller
package trap_controller_pkg;

    localparam logic [3:0] E_FETCH_ADDR_MISALIGNED = 4'd0;
    localparam logic [3:0] E_FETCH_ACCESS_FAULT    = 4'd1;
    localparam logic [3:0] E_ILLEGAL_INSTR         = 4'd2;
    localparam logic [3:0] E_BREAKPOINT            = 4'd3;
    localparam logic [3:0] E_LOAD_ADDR_MISALIGNED  = 4'd4;
    localparam logic [3:0] E_LOAD_ACCESS_FAULT     = 4'd5;
    localparam logic [3:0] E_STORE_ADDR_MISALIGNED = 4'd6;
    localparam logic [3:0] E_STORE_ACCESS_FAULT    = 4'd7;
    localparam logic [3:0] E_ECALL                 = 4'd8;
    localparam logic [3:0] NO_E                    = 4'hF;

    typedef enum logic [1:0] {
        TS_RESET  = 2'd0,
        TS_NORMAL = 2'd1,
        TS_TRAP   = 2'd2,
        TS_HALT   = 2'd3
    } trap_state_t;

    localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR = 32'h0004_0000;
    localparam logic [31:0] TEXT_BASE    = 32'h0008_0000;

    // Regions are distinguished by pc[20:18] alone.
    localparam logic [2:0] REGION_TEXT  = TEXT_BASE[20:18];

endpackage

// File: rtl/trap_controller_exception_code_pipe.sv
// rtl/trap_controller_exception_code_pipe.sv - carries fetch-stage exception codes from F through D to E
module exception_code_pipe
    import trap_controller_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_code_f,
    input  logic       i_stall_d,
    input  logic       i_flush_d,
    input  logic       i_flush_e,
    input  logic       i_flush_fde,
    output logic [3:0] o_code_e
);

    logic [3:0] r_code_d;
    logic [3:0] r_code_e;

    // Flush is checked before stall so a trap can never leave a stale tag held in D.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_code_d <= NO_E;
            r_code_e <= NO_E;
        end else begin
            if (i_flush_d || i_flush_fde) begin
                r_code_d <= NO_E;
            end else if (!i_stall_d) begin
                r_code_d <= i_code_f;
            end
            if (i_flush_e || i_flush_fde) begin
                r_code_e <= NO_E;
            end else begin
                r_code_e <= r_code_d;
            end
        end
    end

    assign o_code_e = r_code_e;

endmodule

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - precise trap FSM, privilege state and mepc/mcause/mtval CSRs
module trap_controller
    import trap_controller_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_pc_f,
    input  logic [3:0]  i_exception_code_f,
    input  logic [3:0]  i_exception_code_e,
    input  logic [31:0] i_pc_e,
    input  logic [31:0] i_alu_out_e,
    input  logic        i_ret_e,
    input  logic        i_stall_d,
    input  logic        i_flush_d,
    input  logic        i_flush_e,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_flush_fde,
    output logic        o_kill_e,
    output logic [31:0] o_mepc,
    output logic [3:0]  o_mcause,
    output logic [31:0] o_mtval,
    output logic        o_reset_permission,
    output logic        o_trap_permission,
    output logic        o_halt
);

    trap_state_t r_state;
    trap_state_t w_state_next;
    logic [31:0] r_mepc;
    logic [3:0]  r_mcause;
    logic [31:0] r_mtval;
    logic        r_reset_perm;
    logic        r_trap_perm;
    logic        r_halt;

    logic [3:0]  w_code_e;
    logic        w_carried;
    logic [3:0]  w_code;
    logic        w_exc;
    logic [31:0] w_tval;
    logic        w_unused_pc;

    exception_code_pipe u_code_pipe (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_code_f    (i_exception_code_f),
        .i_stall_d   (i_stall_d),
        .i_flush_d   (i_flush_d),
        .i_flush_e   (i_flush_e),
        .i_flush_fde (o_flush_fde),
        .o_code_e    (w_code_e)
    );

    // A fetch fault carried with the instruction outranks anything E detects on it.
    assign w_carried   = (w_code_e != NO_E);
    assign w_code      = w_carried ? w_code_e : i_exception_code_e;
    assign w_exc       = (w_code != NO_E);
    assign w_tval      = w_carried ? i_pc_e : i_alu_out_e;
    assign w_unused_pc = ^{i_pc_f[31:21], i_pc_f[17:0]};

    always_comb begin
        o_redirect    = 1'b0;
        o_redirect_pc = 32'h0;
        o_flush_fde   = 1'b0;
        o_kill_e      = 1'b0;
        w_state_next  = r_state;
        if (i_rst_n) begin
            case (r_state)
                TS_RESET: begin
                    if (w_exc) begin
                        o_kill_e     = 1'b1;
                        o_flush_fde  = 1'b1;
                        w_state_next = TS_HALT;
                    end else if (i_pc_f[20:18] == REGION_TEXT) begin
                        w_state_next = TS_NORMAL;
                    end
                end
                TS_NORMAL: begin
                    if (w_exc) begin
                        o_kill_e      = 1'b1;
                        o_flush_fde   = 1'b1;
                        o_redirect    = 1'b1;
                        o_redirect_pc = TRAP_VECTOR;
                        w_state_next  = TS_TRAP;
                    end
                end
                TS_TRAP: begin
                    if (w_exc) begin
                        o_kill_e     = 1'b1;
                        o_flush_fde  = 1'b1;
                        w_state_next = TS_HALT;
                    end else if (i_ret_e) begin
                        o_redirect    = 1'b1;
                        o_redirect_pc = r_mepc + 32'd4;
                        o_flush_fde   = 1'b1;
                        w_state_next  = TS_NORMAL;
                    end
                end
                default: w_state_next = TS_HALT;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= TS_RESET;
            r_mepc       <= 32'h0;
            r_mcause     <= NO_E;
            r_mtval      <= 32'h0;
            r_reset_perm <= 1'b1;
            r_trap_perm  <= 1'b0;
            r_halt       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_reset_perm <= (w_state_next == TS_RESET);
            r_trap_perm  <= (w_state_next == TS_TRAP);
            r_halt       <= (w_state_next == TS_HALT);
            // Only a first-level trap writes the CSRs; a double fault keeps the original cause.
            if (r_state == TS_NORMAL && w_exc) begin
                r_mepc   <= i_pc_e;
                r_mcause <= w_code;
                r_mtval  <= w_tval;
            end
        end
    end

    assign o_mepc             = r_mepc;
    assign o_mcause           = r_mcause;
    assign o_mtval            = r_mtval;
    assign o_reset_permission = r_reset_perm;
    assign o_trap_permission  = r_trap_perm;
    assign o_halt             = r_halt;

endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - directed vector table plus randomized run against a behavioural model
module tb_trap_controller;
    import trap_controller_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] pc_f, pc_e, alu;
    logic [3:0]  code_f, code_e;
    logic        ret, stall, fd, fe;
    logic        redirect, flush_fde, kill_e, rperm, tperm, halt;
    logic [31:0] redirect_pc, mepc, mtval;
    logic [3:0]  mcause;

    trap_controller dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_pc_f             (pc_f),
        .i_exception_code_f (code_f),
        .i_exception_code_e (code_e),
        .i_pc_e             (pc_e),
        .i_alu_out_e        (alu),
        .i_ret_e            (ret),
        .i_stall_d          (stall),
        .i_flush_d          (fd),
        .i_flush_e          (fe),
        .o_redirect         (redirect),
        .o_redirect_pc      (redirect_pc),
        .o_flush_fde        (flush_fde),
        .o_kill_e           (kill_e),
        .o_mepc             (mepc),
        .o_mcause           (mcause),
        .o_mtval            (mtval),
        .o_reset_permission (rperm),
        .o_trap_permission  (tperm),
        .o_halt             (halt)
    );

    typedef struct {
        logic        rst_n;
        logic [31:0] pc_f;
        logic [3:0]  code_f, code_e;
        logic [31:0] pc_e, alu;
        logic        ret, stall, fd, fe;
        logic        redir;
        logic [31:0] rpc;
        logic        kill, flush, rperm, tperm, halt;
        logic [3:0]  mcause;
        logic [31:0] mepc, mtval;
    } vec_t;

    localparam int M_RESET = 0, M_NORMAL = 1, M_TRAP = 2, M_HALT = 3;
    localparam logic [3:0] NO = NO_E;
    localparam logic [3:0] FM = E_FETCH_ADDR_MISALIGNED;
    localparam logic [3:0] IL = E_ILLEGAL_INSTR;
    localparam logic [3:0] SM = E_STORE_ADDR_MISALIGNED;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: privilege mode, the fetch-fault tags riding in D and E, and the CSRs.
    int          m_mode;
    logic [3:0]  m_tag_d, m_tag_e, m_mcause;
    logic [31:0] m_mepc, m_mtval;
    logic        e_redir, e_kill, e_flush;
    logic [31:0] e_rpc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [31:0] pf, input logic [3:0] cf, input logic [3:0] ce,
                                input logic [31:0] pe, input logic [31:0] al, input logic rt, input logic st,
                                input logic d, input logic e, input logic xr, input logic [31:0] xpc, input logic xk,
                                input logic xf, input logic xrp, input logic xtp, input logic xh,
                                input logic [3:0] xc, input logic [31:0] xe, input logic [31:0] xv);
        vec_t v;
        v.rst_n = r; v.pc_f = pf; v.code_f = cf; v.code_e = ce; v.pc_e = pe; v.alu = al;
        v.ret = rt; v.stall = st; v.fd = d; v.fe = e;
        v.redir = xr; v.rpc = xpc; v.kill = xk; v.flush = xf;
        v.rperm = xrp; v.tperm = xtp; v.halt = xh; v.mcause = xc; v.mepc = xe; v.mtval = xv;
        return v;
    endfunction

    task automatic model_reset();
        m_mode = M_RESET; m_tag_d = NO; m_tag_e = NO;
        m_mcause = NO; m_mepc = 32'h0; m_mtval = 32'h0;
    endtask

    task automatic apply(input vec_t v, input bit use_tab);
        logic [3:0]  cause;
        logic [31:0] tval;
        logic        fault;
        @(negedge clk);
        rst_n = v.rst_n; pc_f = v.pc_f; code_f = v.code_f; code_e = v.code_e;
        pc_e = v.pc_e; alu = v.alu; ret = v.ret; stall = v.stall; fd = v.fd; fe = v.fe;
        #1;
        cause = (m_tag_e != NO) ? m_tag_e : v.code_e;
        tval  = (m_tag_e != NO) ? v.pc_e : v.alu;
        fault = (cause != NO);
        e_redir = 0; e_kill = 0; e_flush = 0; e_rpc = 32'h0;
        if (v.rst_n && m_mode != M_HALT) begin
            if (fault) begin
                e_kill = 1; e_flush = 1;
                if (m_mode == M_NORMAL) begin e_redir = 1; e_rpc = TRAP_VECTOR; end
            end else if (m_mode == M_TRAP && v.ret) begin
                e_redir = 1; e_flush = 1; e_rpc = m_mepc + 32'd4;
            end
        end
        chk("redirect", {31'b0, redirect}, {31'b0, e_redir});
        chk("redirect_pc", redirect_pc, e_rpc);
        chk("kill_e", {31'b0, kill_e}, {31'b0, e_kill});
        chk("flush_fde", {31'b0, flush_fde}, {31'b0, e_flush});
        chk("reset_perm", {31'b0, rperm}, {31'b0, m_mode == M_RESET});
        chk("trap_perm", {31'b0, tperm}, {31'b0, m_mode == M_TRAP});
        chk("halt", {31'b0, halt}, {31'b0, m_mode == M_HALT});
        chk("mcause", {28'b0, mcause}, {28'b0, m_mcause});
        chk("mepc", mepc, m_mepc);
        chk("mtval", mtval, m_mtval);
        if (use_tab) begin
            chk("tab_redirect", {31'b0, redirect}, {31'b0, v.redir});
            chk("tab_redirect_pc", redirect_pc, v.rpc);
            chk("tab_kill_e", {31'b0, kill_e}, {31'b0, v.kill});
            chk("tab_flush_fde", {31'b0, flush_fde}, {31'b0, v.flush});
            chk("tab_reset_perm", {31'b0, rperm}, {31'b0, v.rperm});
            chk("tab_trap_perm", {31'b0, tperm}, {31'b0, v.tperm});
            chk("tab_halt", {31'b0, halt}, {31'b0, v.halt});
            chk("tab_mcause", {28'b0, mcause}, {28'b0, v.mcause});
            chk("tab_mepc", mepc, v.mepc);
            chk("tab_mtval", mtval, v.mtval);
        end
        if (!v.rst_n) begin
            model_reset();
        end else begin
            if (m_mode == M_NORMAL && fault) begin
                m_mepc = v.pc_e; m_mcause = cause; m_mtval = tval; m_mode = M_TRAP;
            end else if ((m_mode == M_TRAP || m_mode == M_RESET) && fault) begin
                m_mode = M_HALT;
            end else if (m_mode == M_TRAP && v.ret) begin
                m_mode = M_NORMAL;
            end else if (m_mode == M_RESET && v.pc_f[20:18] == 3'b010) begin
                m_mode = M_NORMAL;
            end
            m_tag_e = (v.fe || e_flush) ? NO : m_tag_d;
            if (v.fd || e_flush) m_tag_d = NO;
            else if (!v.stall)   m_tag_d = v.code_f;
        end
    endtask

    vec_t tab[$];
    vec_t rv;

    initial begin
        rst_n = 0; pc_f = 0; code_f = NO; code_e = NO; pc_e = 0; alu = 0;
        ret = 0; stall = 0; fd = 0; fe = 0;
        repeat (2) @(posedge clk);
        model_reset();

        tab.push_back(mk(1, 32'h0004_0004, NO, NO, 0, 0, 0,0,0,0, 0, 0, 0,0, 1,0,0, NO, 0, 0));
        tab.push_back(mk(1, 32'h0008_0000, NO, NO, 0, 0, 0,0,0,0, 0, 0, 0,0, 1,0,0, NO, 0, 0));
        tab.push_back(mk(1, 32'h0008_0004, NO, NO, 0, 0, 0,0,0,0, 0, 0, 0,0, 0,0,0, NO, 0, 0));
        tab.push_back(mk(1, 32'h0008_0008, NO, SM, 32'h0008_0010, 32'h0010_0002, 0,0,0,0, 1, 0, 1,1, 0,0,0, NO, 0, 0));
        tab.push_back(mk(1, 32'h0000_0000, NO, NO, 0, 0, 0,0,0,0, 0, 0, 0,0, 0,1,0, SM, 32'h0008_0010, 32'h0010_0002));
        tab.push_back(mk(1, 32'h0000_0004, NO, NO, 0, 0, 1,0,0,0, 1, 32'h0008_0014, 0,1, 0,1,0, SM, 32'h0008_0010, 32'h0010_0002));
        tab.push_back(mk(1, 32'h0008_0014, FM, NO, 0, 0, 0,0,0,0, 0, 0, 0,0, 0,0,0, SM, 32'h0008_0010, 32'h0010_0002));
        tab.push_back(mk(1, 32'h0008_0018, NO, NO, 0, 0, 0,0,0,0, 0, 0, 0,0, 0,0,0, SM, 32'h0008_0010, 32'h0010_0002));
        tab.push_back(mk(1, 32'h0008_001c, NO, IL, 32'h0008_0021, 32'hdead, 0,0,0,0, 1, 0, 1,1, 0,0,0, SM, 32'h0008_0010, 32'h0010_0002));
        tab.push_back(mk(1, 32'h0000_0000, NO, NO, 0, 0, 0,0,0,0, 0, 0, 0,0, 0,1,0, FM, 32'h0008_0021, 32'h0008_0021));
        tab.push_back(mk(1, 32'h0000_0004, NO, NO, 0, 0, 1,0,0,0, 1, 32'h0008_0025, 0,1, 0,1,0, FM, 32'h0008_0021, 32'h0008_0021));
        tab.push_back(mk(1, 32'h0008_0025, FM, NO, 0, 0, 0,0,0,0, 0, 0, 0,0, 0,0,0, FM, 32'h0008_0021, 32'h0008_0021));
        tab.push_back(mk(1, 32'h0008_0029, NO, NO, 0, 0, 0,1,0,1, 0, 0, 0,0, 0,0,0, FM, 32'h0008_0021, 32'h0008_0021));
        tab.push_back(mk(1, 32'h0008_0029, NO, NO, 0, 0, 0,0,0,0, 0, 0, 0,0, 0,0,0, FM, 32'h0008_0021, 32'h0008_0021));
        tab.push_back(mk(1, 32'h0008_002d, NO, NO, 32'h0008_0030, 32'h1, 0,0,0,0, 1, 0, 1,1, 0,0,0, FM, 32'h0008_0021, 32'h0008_0021));
        tab.push_back(mk(1, 32'h0000_0000, NO, IL, 0, 0, 1,0,0,0, 0, 0, 1,1, 0,1,0, FM, 32'h0008_0030, 32'h0008_0030));
        tab.push_back(mk(1, 32'h0000_0004, NO, NO, 0, 0, 0,0,0,0, 0, 0, 0,0, 0,0,1, FM, 32'h0008_0030, 32'h0008_0030));
        tab.push_back(mk(1, 32'h0000_0008, NO, SM, 0, 0, 1,0,0,0, 0, 0, 0,0, 0,0,1, FM, 32'h0008_0030, 32'h0008_0030));
        tab.push_back(mk(0, 32'h0000_0008, NO, SM, 0, 0, 1,0,0,0, 0, 0, 0,0, 0,0,1, FM, 32'h0008_0030, 32'h0008_0030));
        tab.push_back(mk(1, 32'h0008_0000, NO, NO, 0, 0, 0,0,0,0, 0, 0, 0,0, 1,0,0, NO, 0, 0));
        tab.push_back(mk(1, 32'h0008_0004, FM, NO, 0, 0, 0,0,0,0, 0, 0, 0,0, 0,0,0, NO, 0, 0));
        tab.push_back(mk(1, 32'h0008_0008, NO, NO, 0, 0, 0,0,0,1, 0, 0, 0,0, 0,0,0, NO, 0, 0));
        tab.push_back(mk(1, 32'h0008_000c, NO, NO, 0, 0, 0,0,0,0, 0, 0, 0,0, 0,0,0, NO, 0, 0));
        tab.push_back(mk(1, 32'h0008_0010, NO, NO, 0, 0, 0,0,0,0, 0, 0, 0,0, 0,0,0, NO, 0, 0));
        tab.push_back(mk(0, 32'h0008_0014, NO, NO, 0, 0, 0,0,0,0, 0, 0, 0,0, 0,0,0, NO, 0, 0));
        tab.push_back(mk(1, 32'h0004_0000, NO, IL, 0, 0, 0,0,0,0, 0, 0, 1,1, 1,0,0, NO, 0, 0));
        tab.push_back(mk(1, 32'h0004_0004, NO, NO, 0, 0, 0,0,0,0, 0, 0, 0,0, 0,0,1, NO, 0, 0));

        foreach (tab[i]) apply(tab[i], 1'b1);

        // Trap return from an mepc near the top of memory wraps around.
        apply(mk(0, 0, NO, NO, 0, 0, 0,0,0,0, 0,0,0,0,0,0,0, NO, 0, 0), 1'b0);
        apply(mk(1, 32'h0008_0000, NO, NO, 0, 0, 0,0,0,0, 0,0,0,0,0,0,0, NO, 0, 0), 1'b0);
        apply(mk(1, 32'h0008_0004, NO, SM, 32'hffff_fffc, 32'h3, 0,0,0,0, 0,0,0,0,0,0,0, NO, 0, 0), 1'b0);
        apply(mk(1, 32'h0000_0000, NO, NO, 0, 0, 1,0,0,0, 1, 32'h0000_0000, 0,1, 0,1,0, SM, 32'hffff_fffc, 32'h3), 1'b1);

        for (int n = 0; n < 3000; n++) begin
            rv = mk(1, 0, NO, NO, 0, 0, 0,0,0,0, 0,0,0,0,0,0,0, NO, 0, 0);
            rv.rst_n  = ($urandom_range(0, 99) != 0);
            rv.pc_f   = $urandom;
            rv.pc_f[20:18] = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'($urandom_range(0, 7));
            rv.code_f = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 8)) : NO;
            rv.code_e = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 8)) : NO;
            rv.pc_e   = $urandom;
            rv.alu    = $urandom;
            rv.ret    = ($urandom_range(0, 3) == 0);
            rv.stall  = ($urandom_range(0, 3) == 0);
            rv.fd     = ($urandom_range(0, 7) == 0);
            rv.fe     = ($urandom_range(0, 7) == 0);
            apply(rv, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
